// File: rtl/univ_shift_reg_pkg.sv
// Shared encodings for the universal shift register:
// operation codes and burst controller states.
package univ_shift_reg_pkg;

   typedef enum logic [2:0] {
      OP_HOLD = 3'd0,
      OP_LOAD = 3'd1,
      OP_SHL  = 3'd2,
      OP_SHR  = 3'd3,
      OP_ROL  = 3'd4,
      OP_ROR  = 3'd5,
      OP_ASR  = 3'd6,
      OP_CLR  = 3'd7
   } op_e;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_BURST = 1'b1
   } state_e;

endpackage

// File: rtl/usr_step_unit.sv
// One combinational step of the register: next value plus
// the expelled bit, used by both single-step and burst paths.
module usr_step_unit
   import univ_shift_reg_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  op_e              op_i,
   input  logic [WIDTH-1:0] d_i,
   input  logic [WIDTH-1:0] load_i,
   input  logic             ser_i,
   output logic [WIDTH-1:0] d_o,
   output logic             sout_o,
   output logic             sout_vld_o
);

   always_comb begin
      d_o        = d_i;
      sout_o     = 1'b0;
      sout_vld_o = 1'b0;
      unique case (op_i)
         OP_HOLD: d_o = d_i;
         OP_LOAD: d_o = load_i;
         OP_SHL: begin
            d_o        = {d_i[WIDTH-2:0], ser_i};
            sout_o     = d_i[WIDTH-1];
            sout_vld_o = 1'b1;
         end
         OP_SHR: begin
            d_o        = {ser_i, d_i[WIDTH-1:1]};
            sout_o     = d_i[0];
            sout_vld_o = 1'b1;
         end
         OP_ROL: begin
            d_o        = {d_i[WIDTH-2:0], d_i[WIDTH-1]};
            sout_o     = d_i[WIDTH-1];
            sout_vld_o = 1'b1;
         end
         OP_ROR: begin
            d_o        = {d_i[0], d_i[WIDTH-1:1]};
            sout_o     = d_i[0];
            sout_vld_o = 1'b1;
         end
         OP_ASR: begin
            d_o        = {d_i[WIDTH-1], d_i[WIDTH-1:1]};
            sout_o     = d_i[0];
            sout_vld_o = 1'b1;
         end
         OP_CLR: d_o = '0;
         default: d_o = d_i;
      endcase
   end

endmodule

// File: rtl/univ_shift_reg.sv
// Universal shift register with single-step ops and
// counted bursts of a latched op.
module univ_shift_reg
   import univ_shift_reg_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int LEN_W = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [2:0]       op,
   input  logic             op_valid,
   input  logic [WIDTH-1:0] data_in,
   input  logic             ser_in,
   input  logic             burst_start,
   input  logic [LEN_W-1:0] burst_len,
   output logic [WIDTH-1:0] data_out,
   output logic             shift_out,
   output logic             busy,
   output logic             done
);

   state_e           state_q, state_d;
   op_e              lop_q, lop_d;
   logic [LEN_W-1:0] count_q, count_d;
   logic [WIDTH-1:0] data_q, data_d;
   logic             sout_q, sout_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;

   op_e              step_op;
   logic [WIDTH-1:0] step_d;
   logic             step_so;
   logic             step_so_vld;

   assign step_op = (state_q == ST_BURST) ? lop_q : op_e'(op);

   usr_step_unit #(.WIDTH(WIDTH)) u_step (
      .op_i       (step_op),
      .d_i        (data_q),
      .load_i     (data_in),
      .ser_i      (ser_in),
      .d_o        (step_d),
      .sout_o     (step_so),
      .sout_vld_o (step_so_vld)
   );

   always_comb begin
      state_d = state_q;
      lop_d   = lop_q;
      count_d = count_q;
      data_d  = data_q;
      sout_d  = sout_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (burst_start) begin
               // A zero-length burst completes immediately.
               if (burst_len != '0) begin
                  lop_d   = op_e'(op);
                  count_d = burst_len;
                  busy_d  = 1'b1;
                  state_d = ST_BURST;
               end else begin
                  done_d = 1'b1;
               end
            end else if (op_valid) begin
               data_d = step_d;
               if (step_so_vld) sout_d = step_so;
            end
         end
         ST_BURST: begin
            data_d  = step_d;
            if (step_so_vld) sout_d = step_so;
            count_d = count_q - 1'b1;
            if (count_q == 1) begin
               state_d = ST_IDLE;
               busy_d  = 1'b0;
               done_d  = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         lop_q   <= OP_HOLD;
         count_q <= '0;
         data_q  <= '0;
         sout_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         lop_q   <= lop_d;
         count_q <= count_d;
         data_q  <= data_d;
         sout_q  <= sout_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign data_out  = data_q;
   assign shift_out = sout_q;
   assign busy      = busy_q;
   assign done      = done_q;

endmodule

// File: tb/tb_univ_shift_reg.sv
// Directed bench for univ_shift_reg: each step queues its
// expected outputs, which are popped and checked after the edge.
module tb_univ_shift_reg;
   import univ_shift_reg_pkg::*;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [2:0] op;
   logic       op_valid;
   logic [7:0] data_in;
   logic       ser_in;
   logic       burst_start;
   logic [3:0] burst_len;
   logic [7:0] data_out;
   logic       shift_out;
   logic       busy;
   logic       done;

   typedef struct {
      string      tag;
      logic [7:0] d;
      logic       so;
      logic       bz;
      logic       dn;
   } exp_t;

   exp_t sb[$];
   int   total  = 0;
   int   passed = 0;

   univ_shift_reg #(.WIDTH(8), .LEN_W(4)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .op          (op),
      .op_valid    (op_valid),
      .data_in     (data_in),
      .ser_in      (ser_in),
      .burst_start (burst_start),
      .burst_len   (burst_len),
      .data_out    (data_out),
      .shift_out   (shift_out),
      .busy        (busy),
      .done        (done)
   );

   always #5 clk = ~clk;

   task automatic step(input string tag, input logic rst,
                       input op_e o, input logic vld,
                       input logic [7:0] din, input logic ser,
                       input logic bs, input logic [3:0] len,
                       input logic [7:0] ed, input logic eso,
                       input logic ebz, input logic edn);
      exp_t e;
      @(negedge clk);
      rst_n       = rst;
      op          = o;
      op_valid    = vld;
      data_in     = din;
      ser_in      = ser;
      burst_start = bs;
      burst_len   = len;
      e.tag = tag; e.d = ed; e.so = eso; e.bz = ebz; e.dn = edn;
      sb.push_back(e);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      total++;
      assert (data_out === e.d) passed++;
      else $error("FAIL %s data_out got %h want %h", e.tag, data_out, e.d);
      total++;
      assert (shift_out === e.so) passed++;
      else $error("FAIL %s shift_out got %b want %b", e.tag, shift_out, e.so);
      total++;
      assert (busy === e.bz) passed++;
      else $error("FAIL %s busy got %b want %b", e.tag, busy, e.bz);
      total++;
      assert (done === e.dn) passed++;
      else $error("FAIL %s done got %b want %b", e.tag, done, e.dn);
   endtask

   initial begin
      rst_n = 1'b0; op = 3'd0; op_valid = 1'b0; data_in = 8'h00;
      ser_in = 1'b0; burst_start = 1'b0; burst_len = 4'd0;
      //    tag        rst op       vld din    ser bs len  data   so bz dn
      step("init_rst",  0, OP_HOLD, 0, 8'h00, 0, 0, 4'd0, 8'h00, 0, 0, 0);
      step("ld_3c",     1, OP_LOAD, 1, 8'h3C, 0, 0, 4'd0, 8'h3C, 0, 0, 0);
      step("rst",       0, OP_LOAD, 1, 8'hFF, 1, 1, 4'd3, 8'h00, 0, 0, 0);
      step("ld_a5",     1, OP_LOAD, 1, 8'hA5, 0, 0, 4'd0, 8'hA5, 0, 0, 0);
      step("shl",       1, OP_SHL,  1, 8'h00, 1, 0, 4'd0, 8'h4B, 1, 0, 0);
      step("shr",       1, OP_SHR,  1, 8'h00, 0, 0, 4'd0, 8'h25, 1, 0, 0);
      step("novalid",   1, OP_CLR,  0, 8'h00, 0, 0, 4'd0, 8'h25, 1, 0, 0);
      step("ld_81",     1, OP_LOAD, 1, 8'h81, 0, 0, 4'd0, 8'h81, 1, 0, 0);
      step("asr",       1, OP_ASR,  1, 8'h00, 0, 0, 4'd0, 8'hC0, 1, 0, 0);
      step("ld_81b",    1, OP_LOAD, 1, 8'h81, 0, 0, 4'd0, 8'h81, 1, 0, 0);
      step("rol",       1, OP_ROL,  1, 8'h00, 0, 0, 4'd0, 8'h03, 1, 0, 0);
      step("hold",      1, OP_HOLD, 1, 8'hEE, 1, 0, 4'd0, 8'h03, 1, 0, 0);
      step("shl0",      1, OP_SHL,  1, 8'h00, 0, 0, 4'd0, 8'h06, 0, 0, 0);
      step("ror",       1, OP_ROR,  1, 8'h00, 0, 0, 4'd0, 8'h03, 0, 0, 0);
      step("ror1",      1, OP_ROR,  1, 8'h00, 0, 0, 4'd0, 8'h81, 1, 0, 0);
      step("clr",       1, OP_CLR,  1, 8'h00, 0, 0, 4'd0, 8'h00, 1, 0, 0);
      step("ld_01",     1, OP_LOAD, 1, 8'h01, 0, 0, 4'd0, 8'h01, 1, 0, 0);
      step("shl_so0",   1, OP_SHL,  1, 8'h00, 1, 0, 4'd0, 8'h03, 0, 0, 0);
      step("ld_01b",    1, OP_LOAD, 1, 8'h01, 0, 0, 4'd0, 8'h01, 0, 0, 0);
      // ROR burst while a CLR request is held on op/op_valid
      step("b_start",   1, OP_ROR,  1, 8'h00, 0, 1, 4'd3, 8'h01, 0, 1, 0);
      step("b_s1",      1, OP_CLR,  1, 8'hFF, 1, 1, 4'd7, 8'h80, 1, 1, 0);
      step("b_s2",      1, OP_CLR,  1, 8'hFF, 1, 1, 4'd7, 8'h40, 0, 1, 0);
      step("b_s3",      1, OP_CLR,  1, 8'hFF, 1, 1, 4'd7, 8'h20, 0, 0, 1);
      step("b_after",   1, OP_CLR,  0, 8'h00, 0, 0, 4'd0, 8'h20, 0, 0, 0);
      step("ld_5a",     1, OP_LOAD, 1, 8'h5A, 0, 0, 4'd0, 8'h5A, 0, 0, 0);
      step("len0",      1, OP_SHL,  1, 8'h00, 1, 1, 4'd0, 8'h5A, 0, 0, 1);
      step("len0_aft",  1, OP_HOLD, 0, 8'h00, 0, 0, 4'd0, 8'h5A, 0, 0, 0);
      // Back-to-back: new burst accepted in the done cycle
      step("ld_c0",     1, OP_LOAD, 1, 8'hC0, 0, 0, 4'd0, 8'hC0, 0, 0, 0);
      step("bb_start",  1, OP_ASR,  0, 8'h00, 0, 1, 4'd1, 8'hC0, 0, 1, 0);
      step("bb_s1",     1, OP_HOLD, 0, 8'h00, 0, 0, 4'd0, 8'hE0, 0, 0, 1);
      step("bb2_start", 1, OP_LOAD, 0, 8'h00, 0, 1, 4'd2, 8'hE0, 0, 1, 0);
      step("bb2_s1",    1, OP_SHL,  0, 8'h77, 0, 0, 4'd0, 8'h77, 0, 1, 0);
      step("bb2_s2",    1, OP_SHL,  0, 8'h99, 0, 0, 4'd0, 8'h99, 0, 0, 1);
      // Reset in the middle of a SHL burst
      step("ld_ff",     1, OP_LOAD, 1, 8'hFF, 0, 0, 4'd0, 8'hFF, 0, 0, 0);
      step("r_start",   1, OP_SHL,  0, 8'h00, 0, 1, 4'd5, 8'hFF, 0, 1, 0);
      step("r_s1",      1, OP_HOLD, 0, 8'h00, 0, 0, 4'd0, 8'hFE, 1, 1, 0);
      step("r_s2",      1, OP_HOLD, 0, 8'h00, 0, 0, 4'd0, 8'hFC, 1, 1, 0);
      step("r_rst",     0, OP_LOAD, 1, 8'hAA, 1, 1, 4'd2, 8'h00, 0, 0, 0);
      step("r_idle1",   1, OP_HOLD, 0, 8'h00, 0, 0, 4'd0, 8'h00, 0, 0, 0);
      step("r_idle2",   1, OP_HOLD, 0, 8'h00, 0, 0, 4'd0, 8'h00, 0, 0, 0);
      step("r_ld_11",   1, OP_LOAD, 1, 8'h11, 0, 0, 4'd0, 8'h11, 0, 0, 0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/univ_shift_reg.md
UNIV_SHIFT_REG -- requirements
Module: univ_shift_reg

Interface
REQ-001 Parameter WIDTH, default 8, register width in bits (SHALL be >= 2).
REQ-002 Parameter LEN_W, default 4, width of burst_len; maximum burst is 2^LEN_W-1 steps.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 op  input  3  operation code: 0 HOLD, 1 LOAD, 2 SHL, 3 SHR, 4 ROL, 5 ROR, 6 ASR, 7 CLR.
REQ-006 op_valid  input  1  request one step of op in the current cycle.
REQ-007 data_in  input  WIDTH  parallel load value for LOAD.
REQ-008 ser_in  input  1  serial fill bit for SHL (enters LSB) and SHR (enters MSB).
REQ-009 burst_start  input  1  request a multi-step burst of op.
REQ-010 burst_len  input  LEN_W  number of steps in the burst.
REQ-011 data_out  output  WIDTH  register contents.
REQ-012 shift_out  output  1  bit expelled by the most recent SHL/SHR/ROL/ROR/ASR step.
REQ-013 busy  output  1  high while a burst is in progress.
REQ-014 done  output  1  one-cycle pulse when a burst completes.

Function
REQ-015 Step semantics: HOLD no change; LOAD data_out<=data_in; SHL {d[W-2:0],ser_in}; SHR {ser_in,d[W-1:1]}; ROL {d[W-2:0],d[W-1]}; ROR {d[0],d[W-1:1]}; ASR {d[W-1],d[W-1:1]}; CLR all zeros.
REQ-016 shift_out SHALL take d[W-1] on SHL/ROL and d[0] on SHR/ROR/ASR, on the same edge as data_out; it SHALL hold its value for HOLD/LOAD/CLR.
REQ-017 The FSM SHALL have two states: IDLE and BURST.
REQ-018 In IDLE with op_valid=1 and burst_start=0, one step SHALL be applied on that edge (latency 1).
REQ-019 In IDLE with burst_start=1 and burst_len!=0: op and burst_len SHALL be latched, busy<=1, state<=BURST, and data_out SHALL NOT change on that edge.
REQ-020 burst_start SHALL take priority over op_valid when both are asserted in IDLE.
REQ-021 In BURST, each edge SHALL apply one step of the latched op and decrement the remaining count.
REQ-022 On the edge where the remaining count goes 1->0: state<=IDLE, busy<=0, done<=1.
REQ-023 done SHALL be high for exactly one cycle and SHALL be 0 otherwise.
REQ-024 Burst with burst_len=0: no state change, no data change, busy stays 0, done<=1 on that edge.
REQ-025 Burst of HOLD/LOAD/CLR SHALL apply the op burst_len times (idempotent), timing per REQ-021/022.
REQ-026 In BURST, op_valid, burst_start, op, burst_len and data_in SHALL be ignored, except that data_in is sampled for a latched LOAD on each step edge.
REQ-027 A new burst_start is accepted in the cycle done is high (state is IDLE).

Reset
REQ-028 With rst_n=0 at an edge: data_out<=0, shift_out<=0, busy<=0, done<=0, state<=IDLE, count<=0, regardless of the current state, including mid-burst.
REQ-029 While rst_n=0, all other inputs SHALL be ignored.

Structure
REQ-030 Package univ_shift_reg_pkg SHALL hold the op encoding enum and the IDLE/BURST state enum.
REQ-031 Combinational next-value/expelled-bit logic SHALL be a sub-module, usr_step_unit (inputs: op, d, ser_in; outputs: next d, out bit, out-bit-valid), shared by the single-step and burst paths.
REQ-032 The design SHALL contain no latches and no clock gating.

Verification (WIDTH=8, LEN_W=4)
REQ-033 Reset: data_out=0x3C, rst_n=0 for one edge -> data_out=0x00, busy=0, done=0, shift_out=0.
REQ-034 LOAD 0xA5, then SHL with ser_in=1 -> 0x4B, shift_out=1; then SHR with ser_in=0 -> 0x25, shift_out=1.
REQ-035 LOAD 0x81: ASR -> 0xC0, shift_out=1; reload 0x81, ROL -> 0x03, shift_out=1.
REQ-036 LOAD 0x01, burst ROR len=3, op_valid=1 with op=CLR held throughout -> start edge no change; then 0x80, 0x40, 0x20; busy high 3 cycles; done pulse after last step; CLR never applied.
REQ-037 Burst with burst_len=0 on 0x5A -> data stays 0x5A, busy never high, done high one cycle.
REQ-038 Burst SHL len=5 from 0xFF, ser_in=0, rst_n=0 after 2 steps (data=0xFC) -> data_out=0x00, busy=0, no done pulse; a subsequent op_valid LOAD 0x11 -> 0x11.
